// File: rtl/sobel_edge_pkg.sv
// Shared VP constants and helpers for the Sobel edge stage.
// Define SOBEL_MAG_OUT_EN to build the grey magnitude output.
package sobel_edge_pkg;

   localparam logic [7:0]  LUMA_R     = 8'd77;
   localparam logic [7:0]  LUMA_G     = 8'd150;
   localparam logic [7:0]  LUMA_B     = 8'd29;
   localparam int          LUMA_SHIFT = 8;
   localparam int          SOBEL_LAT  = 4;
   localparam logic [23:0] BIN_WHITE  = 24'hFFFFFF;

   typedef struct packed {
      logic        vs;
      logic        de;
      logic        en;
      logic        ok;
      logic [23:0] data;
   } meta_t;

   function automatic logic [7:0] luma(input logic [23:0] rgb);
      logic [15:0] s;
      s = {8'd0, LUMA_R} * {8'd0, rgb[23:16]}
        + {8'd0, LUMA_G} * {8'd0, rgb[15:8]}
        + {8'd0, LUMA_B} * {8'd0, rgb[7:0]};
      s = s >> LUMA_SHIFT;
      return s[7:0];
   endfunction

   function automatic logic [9:0] tri_sum(
      input logic [7:0] a,
      input logic [7:0] b,
      input logic [7:0] c
   );
      return {2'b0, a} + {1'b0, b, 1'b0} + {2'b0, c};
   endfunction

   // |pos - neg| of the two weighted column/row sums
   function automatic logic [10:0] grad_abs(
      input logic [9:0] pos,
      input logic [9:0] neg
   );
      logic [9:0] d;
      d = (pos >= neg) ? (pos - neg) : (neg - pos);
      return {1'b0, d};
   endfunction

endpackage

// File: rtl/sobel_linebuf.sv
// Two luma line buffers: row1 holds line y-1, row2 holds line y-2.
// Row2 is refilled one cycle later from the value just read out of row1.
module sobel_linebuf
   import sobel_edge_pkg::*;
#(
   parameter int DEPTH = 1280,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [7:0]    din,
   output logic [7:0]    row1,
   output logic [7:0]    row2
);

   logic [7:0]    mem1 [DEPTH];
   logic [7:0]    mem2 [DEPTH];
   logic          we_q;
   logic [AW-1:0] addr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row1   <= '0;
         row2   <= '0;
         we_q   <= 1'b0;
         addr_q <= '0;
      end else begin
         row1   <= mem1[addr];
         row2   <= mem2[addr];
         we_q   <= we;
         addr_q <= addr;
      end
   end

   always_ff @(posedge clk) begin
      if (we)
         mem1[addr] <= din;
      if (we_q)
         mem2[addr_q] <= row1;
   end

endmodule

// File: rtl/sobel_edge.sv
// Streaming Sobel edge detector on the filter's vs/de/RGB888 stream.
// Fixed 4-cycle latency; SOBEL_MAG_OUT_EN adds a grey magnitude mode.
module sobel_edge
   import sobel_edge_pkg::*;
#(
   parameter logic [11:0] IMG_HDISP = 12'd1280,
   parameter logic [11:0] IMG_VDISP = 12'd720
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        EN,
   input  logic        bin_mode,
   input  logic [7:0]  threshold,
   input  logic        pre_vs,
   input  logic        pre_de,
   input  logic [23:0] pre_data,
   output logic        post_vs,
   output logic        post_de,
   output logic [23:0] post_data
);

   localparam int AW = $clog2(int'(IMG_HDISP));

   logic        vs_q;
   logic        de_q;
   logic [11:0] col_q;
   logic [11:0] row_q;
   logic [11:0] cur_col;
   logic [11:0] cur_row;
   logic        vs_rise;
   logic        de_fall;
   logic        we0;
   logic        ok0;

   assign vs_rise = pre_vs & ~vs_q;
   assign de_fall = de_q & ~pre_de;
   assign cur_col = vs_rise ? 12'd0 : col_q;
   assign cur_row = vs_rise ? 12'd0 : row_q;
   assign we0     = pre_de & (cur_col < IMG_HDISP);
   assign ok0     = we0 & (cur_col >= 12'd2) & (cur_row >= 12'd2);

   // frame start wins over every other counter update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_q  <= 1'b0;
         de_q  <= 1'b0;
         col_q <= '0;
         row_q <= '0;
      end else begin
         vs_q <= pre_vs;
         de_q <= pre_de;
         if (vs_rise)
            col_q <= pre_de ? 12'd1 : 12'd0;
         else if (pre_de) begin
            if (col_q < IMG_HDISP)
               col_q <= col_q + 12'd1;
         end else if (de_fall)
            col_q <= '0;
         if (vs_rise)
            row_q <= '0;
         else if (de_fall && (row_q < IMG_VDISP - 12'd1))
            row_q <= row_q + 12'd1;
      end
   end

   logic [7:0]    y1;
   logic [AW-1:0] addr1;
   logic          we1;
   logic [7:0]    y2;
   logic          sh2;
   logic [7:0]    lb_row1;
   logic [7:0]    lb_row2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y1    <= '0;
         addr1 <= '0;
         we1   <= 1'b0;
         y2    <= '0;
         sh2   <= 1'b0;
      end else begin
         y1    <= luma(pre_data);
         addr1 <= cur_col[AW-1:0];
         we1   <= we0;
         y2    <= y1;
         sh2   <= we1;
      end
   end

   sobel_linebuf #(
      .DEPTH (int'(IMG_HDISP)),
      .AW    (AW)
   ) u_linebuf (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we1),
      .addr  (addr1),
      .din   (y1),
      .row1  (lb_row1),
      .row2  (lb_row2)
   );

   // w[r][c]: r=0 is line y-2, c=2 is the newest column
   logic [7:0] w [3][3];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               w[r][c] <= '0;
      end else if (sh2) begin
         for (int r = 0; r < 3; r++) begin
            w[r][0] <= w[r][1];
            w[r][1] <= w[r][2];
         end
         w[0][2] <= lb_row2;
         w[1][2] <= lb_row1;
         w[2][2] <= y2;
      end
   end

   meta_t dly [SOBEL_LAT-1];
   meta_t m;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SOBEL_LAT - 1; i++)
            dly[i] <= '0;
      end else begin
         dly[0] <= {pre_vs, pre_de, EN, ok0, pre_data};
         for (int i = 1; i < SOBEL_LAT - 1; i++)
            dly[i] <= dly[i-1];
      end
   end

   assign m = dly[SOBEL_LAT-2];

   logic [10:0] gx_abs;
   logic [10:0] gy_abs;
   logic [10:0] mag;
   logic [23:0] bin_px;
   logic [23:0] edge_px;

   assign gx_abs = grad_abs(tri_sum(w[0][2], w[1][2], w[2][2]),
                            tri_sum(w[0][0], w[1][0], w[2][0]));
   assign gy_abs = grad_abs(tri_sum(w[2][0], w[2][1], w[2][2]),
                            tri_sum(w[0][0], w[0][1], w[0][2]));
   assign mag    = gx_abs + gy_abs;
   assign bin_px = (mag > {3'b0, threshold}) ? BIN_WHITE : 24'h0;

`ifdef SOBEL_MAG_OUT_EN
   logic [7:0] sat;
   assign sat     = (mag > 11'd255) ? 8'hFF : mag[7:0];
   assign edge_px = bin_mode ? bin_px : {sat, sat, sat};
`else
   logic unused_cfg;
   assign unused_cfg = bin_mode;
   assign edge_px    = bin_px;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         post_vs   <= 1'b0;
         post_de   <= 1'b0;
         post_data <= '0;
      end else begin
         post_vs   <= m.vs;
         post_de   <= m.de;
         post_data <= m.en ? (m.ok ? edge_px : 24'h0) : m.data;
      end
   end

endmodule
